// File: rtl/gauss_writeback_if.sv
// Stream-in / SRAM-write bundle for gauss_writeback: 7-pixel group handshake plus byte write port.
// The master modport is the writeback block's view; slave is the surrounding environment.
interface gauss_writeback_if #(
  parameter int ADDR_W = 18
);
  logic              gauss_valid;
  logic              gauss_ready;
  logic [7:0]        gauss_in [0:6];
  logic              sram_wr_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_wdata;
  logic              sram_ready;

  modport master (
    input  gauss_valid, gauss_in, sram_ready,
    output gauss_ready, sram_wr_en, sram_addr, sram_wdata
  );

  modport slave (
    output gauss_valid, gauss_in, sram_ready,
    input  gauss_ready, sram_wr_en, sram_addr, sram_wdata
  );
endinterface

// File: rtl/gauss_writeback.sv
// Buffers 7-pixel Gaussian groups in two ping-pong slots and drains them byte-by-byte to SRAM.
// Define GAUSS_WB_CHECKSUM_EN to add the wr_checksum running byte-sum output.
module gauss_writeback #(
  parameter int ADDR_W     = 18,
  parameter int BASE_ADDR  = 0,
  parameter int IMG_PIXELS = 4200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  output logic        frame_done,
`ifdef GAUSS_WB_CHECKSUM_EN
  output logic [15:0] wr_checksum,
`endif
  gauss_writeback_if.master bus
);

  // IMG_PIXELS must be a nonzero multiple of 7 so frame ends always coincide with pixel 6 of a slot.
  localparam int                PIX_W    = $clog2(IMG_PIXELS);
  localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(IMG_PIXELS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [7:0]        slot_data [0:1][0:6];
  logic [1:0]        slot_full;
  logic [1:0]        full_next;
  logic              wr_sel;
  logic              rd_sel;
  logic [2:0]        k;
  logic [PIX_W-1:0]  pix_cnt;
  logic [ADDR_W-1:0] addr;
  logic              ready_q;

  logic accept;
  logic wr_accept;
  logic last_k;
  logic last_pix;
  logic restart;

  assign accept    = bus.gauss_valid & ready_q;
  assign wr_accept = (state == S_WRITE) & bus.sram_ready;
  assign last_k    = (k == 3'd6);
  assign last_pix  = (pix_cnt == LAST_PIX);
  assign restart   = frame_start & (state == S_IDLE) & (slot_full == 2'b00);

  // Slots behave as a 2-entry FIFO: the empty slot is always wr_sel, the head is rd_sel.
  always_comb begin
    full_next = slot_full;
    if (wr_accept && last_k) full_next[rd_sel] = 1'b0;
    if (accept)              full_next[wr_sel] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (slot_full != 2'b00) state_next = S_WRITE;
      S_WRITE: begin
        if (wr_accept && last_pix)    state_next = S_DONE;
        else if (wr_accept && last_k) state_next = slot_full[~rd_sel] ? S_WRITE : S_IDLE;
      end
      S_DONE:  state_next = (slot_full != 2'b00) ? S_WRITE : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ready_q is computed from next-cycle occupancy so a slot freed on an edge is offered right after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      slot_full <= 2'b00;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      k         <= 3'd0;
      pix_cnt   <= '0;
      addr      <= BASE;
      ready_q   <= 1'b0;
    end else begin
      state     <= state_next;
      slot_full <= full_next;
      ready_q   <= ~&full_next;
      if (accept) wr_sel <= ~wr_sel;
      if (wr_accept) begin
        k <= last_k ? 3'd0 : k + 3'd1;
        if (last_k) rd_sel <= ~rd_sel;
        if (last_pix) begin
          pix_cnt <= '0;
          addr    <= BASE;
        end else begin
          pix_cnt <= pix_cnt + PIX_W'(1);
          addr    <= addr + ADDR_W'(1);
        end
      end else if (restart) begin
        pix_cnt <= '0;
        addr    <= BASE;
      end
    end
  end

  // Pixel storage needs no reset: occupancy flags alone decide whether a slot is meaningful.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 7; i++) slot_data[wr_sel][i] <= bus.gauss_in[i];
    end
  end

  assign bus.gauss_ready = ready_q;
  assign bus.sram_wr_en  = (state == S_WRITE);
  assign bus.sram_addr   = addr;
  assign bus.sram_wdata  = (state == S_WRITE) ? slot_data[rd_sel][k] : 8'h00;
  assign frame_done      = (state == S_DONE);

`ifdef GAUSS_WB_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            wr_checksum <= 16'h0000;
    else if (restart)   wr_checksum <= 16'h0000;
    else if (wr_accept) wr_checksum <= wr_checksum + {8'h00, bus.sram_wdata};
  end
`endif

endmodule

// File: tb/tb_gauss_writeback.sv
// Self-checking bench for gauss_writeback: directed vector table, hand-written corner sequences,
// and a randomized run checked by a byte-queue reference model.
module tb_gauss_writeback;
  localparam int ADDR_W     = 18;
  localparam int BASE_ADDR  = 256;
  localparam int IMG_PIXELS = 14;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef struct {
    logic              valid;
    logic [55:0]       grp;
    logic              rdy;
    logic              fstart;
    logic              exp_wr;
    logic [ADDR_W-1:0] exp_addr;
    logic [7:0]        exp_data;
    logic              exp_ready;
    logic              exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start;
  logic frame_done;
`ifdef GAUSS_WB_CHECKSUM_EN
  logic [15:0] wr_checksum;
`endif

  gauss_writeback_if #(.ADDR_W(ADDR_W)) bus ();

  gauss_writeback #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .IMG_PIXELS(IMG_PIXELS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .frame_done(frame_done),
`ifdef GAUSS_WB_CHECKSUM_EN
    .wr_checksum(wr_checksum),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: bytes accepted but not yet written, position within the frame, pending frame_done.
  logic [7:0]  exp_q [$];
  int          pix_idx = 0;
  logic        done_due = 1'b0;
  logic        ready_armed = 1'b0;
  logic [15:0] exp_sum = 16'h0;
  logic [7:0]  mon_d;
  logic        mon_new_done;
  logic        mon_q_empty;
  vec_t        vecs [$];

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pix_idx     = 0;
      done_due    = 1'b0;
      ready_armed = 1'b0;
      exp_sum     = 16'h0;
    end else begin
      mon_q_empty  = (exp_q.size() == 0);
      mon_new_done = 1'b0;
      compare("mon_ready", 32'(bus.gauss_ready), 32'(ready_armed && exp_q.size() <= 7));
      compare("mon_frame_done", 32'(frame_done), 32'(done_due));
`ifdef GAUSS_WB_CHECKSUM_EN
      compare("mon_checksum", 32'(wr_checksum), 32'(exp_sum));
`endif
      if (done_due && bus.sram_wr_en) compare("mon_write_in_done", 32'(bus.sram_wr_en), 32'd0);
      if (bus.sram_wr_en && bus.sram_ready) begin
        if (mon_q_empty) begin
          compare("mon_spurious_write", 32'(bus.sram_wr_en), 32'd0);
        end else begin
          mon_d = exp_q.pop_front();
          compare("mon_wdata", 32'(bus.sram_wdata), 32'(mon_d));
          compare("mon_addr", 32'(bus.sram_addr), 32'(BASE + ADDR_W'(pix_idx)));
          exp_sum = exp_sum + 16'(mon_d);
          pix_idx++;
          if (pix_idx == IMG_PIXELS) begin
            pix_idx      = 0;
            mon_new_done = 1'b1;
          end
        end
      end
      if (frame_start && mon_q_empty && !done_due) begin
        pix_idx = 0;
        exp_sum = 16'h0;
      end
      if (bus.gauss_valid && bus.gauss_ready) begin
        for (int i = 0; i < 7; i++) exp_q.push_back(bus.gauss_in[i]);
      end
      done_due    = mon_new_done;
      ready_armed = 1'b1;
    end
  end

  function automatic logic [55:0] mk_group(input logic [7:0] seed);
    logic [55:0] g;
    for (int i = 0; i < 7; i++) g[8*i +: 8] = seed + 8'(10 * i);
    return g;
  endfunction

  task automatic add_vec(input logic v, input logic [55:0] g, input logic r, input logic fs,
                         input logic ew, input logic [ADDR_W-1:0] ea, input logic [7:0] ed,
                         input logic er, input logic edn);
    vec_t t;
    t.valid = v; t.grp = g; t.rdy = r; t.fstart = fs;
    t.exp_wr = ew; t.exp_addr = ea; t.exp_data = ed; t.exp_ready = er; t.exp_done = edn;
    vecs.push_back(t);
  endtask

  task automatic applyStimulus(input logic v, input logic [55:0] g, input logic r, input logic fs);
    bus.gauss_valid = v;
    for (int i = 0; i < 7; i++) bus.gauss_in[i] = g[8*i +: 8];
    bus.sram_ready = r;
    frame_start    = fs;
  endtask

  task automatic checkOutput(input string name, input logic ew, input logic [ADDR_W-1:0] ea,
                             input logic [7:0] ed, input logic er, input logic edn);
    logic ok;
    tests_run++;
    ok = (bus.sram_wr_en === ew) && (bus.sram_addr === ea) && (bus.gauss_ready === er) &&
         (frame_done === edn) && (!ew || bus.sram_wdata === ed);
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL %s: got wr=%b addr=%0h data=%0h ready=%b done=%b, expected wr=%b addr=%0h data=%0h ready=%b done=%b",
               name, bus.sram_wr_en, bus.sram_addr, bus.sram_wdata, bus.gauss_ready, frame_done,
               ew, ea, ed, er, edn);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_outputs", 1'b0, BASE, 8'h00, 1'b0, 1'b0);
    compare("reset_wdata", 32'(bus.sram_wdata), 32'd0);
`ifdef GAUSS_WB_CHECKSUM_EN
    compare("reset_checksum", 32'(wr_checksum), 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_low_before_edge", 1'b0, BASE, 8'h00, 1'b0, 1'b0);
    tick();
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    applyStimulus(1'b0, 56'h0, 1'b1, 1'b0);
    while ((exp_q.size() != 0 || done_due) && n < 300) begin
      tick();
      n++;
    end
    compare(name, 32'(n < 300), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] rnd;

    // One group, then a second that completes the 14-pixel frame and wraps the address.
    add_vec(1'b1, mk_group(8'd10), 1'b1, 1'b0, 1'b0, BASE, 8'h00, 1'b1, 1'b0);
    add_vec(1'b0, 56'h0, 1'b1, 1'b0, 1'b0, BASE, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++)
      add_vec(1'b0, 56'h0, 1'b1, 1'b0, 1'b1, BASE + ADDR_W'(k), 8'(10 + 10 * k), 1'b1, 1'b0);
    add_vec(1'b0, 56'h0, 1'b1, 1'b0, 1'b0, BASE + ADDR_W'(7), 8'h00, 1'b1, 1'b0);
    add_vec(1'b1, mk_group(8'd100), 1'b1, 1'b0, 1'b0, BASE + ADDR_W'(7), 8'h00, 1'b1, 1'b0);
    add_vec(1'b0, 56'h0, 1'b1, 1'b0, 1'b0, BASE + ADDR_W'(7), 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++)
      add_vec(1'b0, 56'h0, 1'b1, 1'b0, 1'b1, BASE + ADDR_W'(7 + k), 8'(100 + 10 * k), 1'b1, 1'b0);
    add_vec(1'b0, 56'h0, 1'b1, 1'b0, 1'b0, BASE, 8'h00, 1'b1, 1'b1);
    add_vec(1'b0, 56'h0, 1'b1, 1'b0, 1'b0, BASE, 8'h00, 1'b1, 1'b0);

    applyStimulus(1'b0, 56'h0, 1'b0, 1'b0);
    doReset();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].grp, vecs[i].rdy, vecs[i].fstart);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_wr, vecs[i].exp_addr, vecs[i].exp_data,
                  vecs[i].exp_ready, vecs[i].exp_done);
      tick();
    end

    // Three groups back-to-back against a stalled SRAM.
    doReset();
    applyStimulus(1'b1, mk_group(8'd1), 1'b0, 1'b0);
    @(negedge clk); checkOutput("bp_accept_a", 1'b0, BASE, 8'h00, 1'b1, 1'b0); tick();
    applyStimulus(1'b1, mk_group(8'd80), 1'b0, 1'b0);
    @(negedge clk); checkOutput("bp_accept_b", 1'b0, BASE, 8'h00, 1'b1, 1'b0); tick();
    applyStimulus(1'b1, mk_group(8'd150), 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); checkOutput($sformatf("bp_stall%0d", s), 1'b1, BASE, 8'd1, 1'b0, 1'b0); tick();
    end
    applyStimulus(1'b1, mk_group(8'd150), 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_a%0d", k), 1'b1, BASE + ADDR_W'(k), 8'(1 + 10 * k), 1'b0, 1'b0);
      tick();
    end
    @(negedge clk); checkOutput("bp_no_bubble", 1'b1, BASE + ADDR_W'(7), 8'd80, 1'b1, 1'b0); tick();
    applyStimulus(1'b0, 56'h0, 1'b1, 1'b0);
    @(negedge clk); checkOutput("bp_full_again", 1'b1, BASE + ADDR_W'(8), 8'd90, 1'b0, 1'b0); tick();
    waitDrain("bp_drain");

    // Reset in the middle of pixel 3, then frame_start during WRITE and in IDLE.
    doReset();
    applyStimulus(1'b1, mk_group(8'd30), 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 56'h0, 1'b1, 1'b0);
    repeat (4) tick();
    @(negedge clk); checkOutput("abort_pre", 1'b1, BASE + ADDR_W'(3), 8'd60, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 checkOutput("abort_async", 1'b0, BASE, 8'h00, 1'b0, 1'b0);
    compare("abort_wdata", 32'(bus.sram_wdata), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); checkOutput("abort_ready_low", 1'b0, BASE, 8'h00, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, mk_group(8'd40), 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 56'h0, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b0, 56'h0, 1'b1, k == 2);
      @(negedge clk);
      checkOutput($sformatf("fs_ignored%0d", k), 1'b1, BASE + ADDR_W'(k), 8'(40 + 10 * k), 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 56'h0, 1'b1, 1'b1);
    @(negedge clk); checkOutput("fs_idle_before", 1'b0, BASE + ADDR_W'(7), 8'h00, 1'b1, 1'b0); tick();
    applyStimulus(1'b0, 56'h0, 1'b1, 1'b0);
    @(negedge clk); checkOutput("fs_idle_after", 1'b0, BASE, 8'h00, 1'b1, 1'b0);
`ifdef GAUSS_WB_CHECKSUM_EN
    compare("fs_checksum_clear", 32'(wr_checksum), 32'd0);
`endif
    tick();
    applyStimulus(1'b1, {7{8'hff}}, 1'b1, 1'b0);
    tick();
    waitDrain("ff_drain");
    @(negedge clk); checkOutput("ff_end", 1'b0, BASE + ADDR_W'(7), 8'h00, 1'b1, 1'b0);
`ifdef GAUSS_WB_CHECKSUM_EN
    compare("ff_checksum", 32'(wr_checksum), 32'd1785);
`endif
    tick();

    // Randomized traffic checked entirely by the reference model.
    for (int c = 0; c < 2000; c++) begin
      rnd = {$urandom(), $urandom()};
      applyStimulus($urandom_range(0, 2) != 0, rnd[55:0], $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0);
      tick();
    end
    waitDrain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
